// File: rtl/floo_mcast_fork_buffer.sv
// Per-VC multicast fork: replicates each input flit to every output in its destination mask,
// either lock-step (no storage) or through per-(output,VC) decoupling FIFOs.
module floo_mcast_fork_buffer #(
  parameter int unsigned NumOutputs      = 4,
  parameter int unsigned NumVirtChannels = 2,
  parameter type         flit_t          = logic,
  parameter int unsigned OutFifoDepth    = 2,
  parameter bit          EnableWormhole  = 1'b1,
  parameter int unsigned StallCntWidth   = 8
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic  [NumVirtChannels-1:0]                      valid_i,
  output logic  [NumVirtChannels-1:0]                      ready_o,
  input  flit_t [NumVirtChannels-1:0]                      data_i,
  input  logic  [NumVirtChannels-1:0][NumOutputs-1:0]      mask_i,
  input  logic  [NumVirtChannels-1:0]                      last_i,
  output logic  [NumOutputs-1:0][NumVirtChannels-1:0]      valid_o,
  input  logic  [NumOutputs-1:0][NumVirtChannels-1:0]      ready_i,
  output flit_t [NumOutputs-1:0][NumVirtChannels-1:0]      data_o,
  output logic  [NumVirtChannels-1:0]                      drop_o,
  output logic  [NumVirtChannels-1:0]                      stall_o
);

  localparam int unsigned PtrW = (OutFifoDepth > 1) ? $clog2(OutFifoDepth) : 1;
  localparam int unsigned CntW = (OutFifoDepth > 0) ? $clog2(OutFifoDepth + 1) : 1;

  for (genvar v = 0; v < NumVirtChannels; v++) begin : g_vc
    logic [NumOutputs-1:0]    eff;
    logic                     lock_q;
    logic                     accept;
    logic                     drop_q;
    logic [StallCntWidth-1:0] stall_cnt_q;

    assign accept = valid_i[v] & ready_o[v];

    if (EnableWormhole) begin : g_worm
      logic [NumOutputs-1:0] mask_q;

      // A head flit with an empty mask also locks, so its whole packet is dropped.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          lock_q <= 1'b0;
          mask_q <= '0;
        end else if (accept) begin
          if (last_i[v]) begin
            lock_q <= 1'b0;
          end else if (!lock_q) begin
            lock_q <= 1'b1;
            mask_q <= mask_i[v];
          end
        end
      end

      assign eff = lock_q ? mask_q : mask_i[v];
    end else begin : g_no_worm
      assign lock_q = 1'b0;
      assign eff    = mask_i[v];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        drop_q      <= 1'b0;
        stall_cnt_q <= '0;
      end else begin
        drop_q <= accept & ~|eff;
        if (accept) begin
          stall_cnt_q <= '0;
        end else if (valid_i[v] && (stall_cnt_q != '1)) begin
          stall_cnt_q <= stall_cnt_q + StallCntWidth'(1);
        end
      end
    end

    assign drop_o[v]  = drop_q;
    assign stall_o[v] = &stall_cnt_q;

    if (OutFifoDepth == 0) begin : g_lockstep
      logic [NumOutputs-1:0] done_q;
      logic [NumOutputs-1:0] fwd;
      logic [NumOutputs-1:0] sent;

      for (genvar o = 0; o < NumOutputs; o++) begin : g_out
        assign fwd[o]        = valid_i[v] & eff[o] & ~done_q[o];
        assign sent[o]       = fwd[o] & ready_i[o][v];
        assign valid_o[o][v] = fwd[o];
        assign data_o[o][v]  = data_i[v];
      end

      assign ready_o[v] = &(~eff | done_q | sent);

      // done_q remembers outputs already served so a stalled flit is never duplicated.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          done_q <= '0;
        end else if (accept) begin
          done_q <= '0;
        end else begin
          done_q <= done_q | sent;
        end
      end
    end else begin : g_buffered
      logic [NumOutputs-1:0] full;

      for (genvar o = 0; o < NumOutputs; o++) begin : g_out
        flit_t            mem_q [OutFifoDepth];
        logic [PtrW-1:0]  wptr_q, rptr_q;
        logic [CntW-1:0]  cnt_q;
        logic             push, pop;

        assign full[o]       = (cnt_q == CntW'(OutFifoDepth));
        assign push          = accept & eff[o];
        assign pop           = valid_o[o][v] & ready_i[o][v];
        assign valid_o[o][v] = (cnt_q != '0);
        assign data_o[o][v]  = mem_q[rptr_q];

        always_ff @(posedge clk_i) begin
          if (push) begin
            mem_q[wptr_q] <= data_i[v];
          end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
          end else begin
            if (push) begin
              wptr_q <= (wptr_q == PtrW'(OutFifoDepth - 1)) ? '0 : wptr_q + PtrW'(1);
            end
            if (pop) begin
              rptr_q <= (rptr_q == PtrW'(OutFifoDepth - 1)) ? '0 : rptr_q + PtrW'(1);
            end
            cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
          end
        end
      end

      // Fullness is taken from registered counts: a same-cycle pop does not free a slot.
      assign ready_o[v] = &(~eff | ~full);
    end

    assert property (@(posedge clk_i) disable iff (rst_i)
      valid_i[v] && !ready_o[v] |=> valid_i[v]);
    assert property (@(posedge clk_i) disable iff (rst_i)
      valid_i[v] && !ready_o[v] && !lock_q |=> $stable(mask_i[v]));
    for (genvar o = 0; o < NumOutputs; o++) begin : g_out_chk
      assert property (@(posedge clk_i) disable iff (rst_i)
        valid_o[o][v] && !ready_i[o][v] |=> valid_o[o][v]);
    end
  end

endmodule
